// File: rtl/fifo_writer_pkg.sv
// Shared definitions for the stream-to-async-FIFO writer.
//   - DEF_DATA_WIDTH / DEF_CNT_WIDTH : default payload and counter widths
//   - state_e                        : frame FSM state encoding
// The HEADER state is only reachable when FIFO_WR_HEADER_EN is defined.
package fifo_writer_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_stream_writer_if.sv
// Source stream handshake between a payload producer and fifo_stream_writer.
//   s_data  : payload word (producer -> writer)
//   s_valid : s_data is valid (producer -> writer)
//   s_last  : last payload word of a frame (producer -> writer)
//   s_ready : writer accepts s_data this cycle (writer -> producer)
// Modports: master = producer side, slave = writer side.
interface fifo_stream_writer_if
  import fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/fifo_wr_stage.sv
// Single-entry output register in front of an async FIFO write port.
//   clk, rst_n : write clock, asynchronous active-low reset
//   load       : capture load_data this cycle (caller guarantees ~out_valid | ~full)
//   load_data  : word to capture
//   full       : FIFO full flag
//   out_valid  : register holds a word not yet written
//   wr_en      : FIFO write strobe, out_valid & ~full
//   wr_data    : held word
module fifo_wr_stage
  import fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  full,
  output logic                  out_valid,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  assign wr_en     = out_valid_q & ~full;
  assign wr_data   = out_data_q;
  assign out_valid = out_valid_q;

  // A write empties the register; a load in the same cycle refills it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (wr_en) begin
      out_valid_d = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: rtl/fifo_stream_writer.sv
// Frames a valid/ready/last source stream into writes on an async FIFO
// write port, with an optional per-frame length limit.
//   wr_clk, wr_rst_n : write clock, asynchronous active-low reset
//   enable           : start new frames (looked at only in IDLE)
//   max_len          : payload word limit per frame, 0 = unlimited
//   s_if             : source stream (slave side)
//   wr_data, wr_en   : FIFO write port; full is the FIFO full flag
//   frame_cnt        : frames completed since reset
//   word_cnt         : payload words accepted in the current frame
//   busy             : FSM active or a word is still held
//   len_err          : sticky, a frame was truncated at max_len
// Build option: define FIFO_WR_HEADER_EN to emit frame_cnt as a header word
// ahead of each frame's payload.
module fifo_stream_writer
  import fifo_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  max_len,
  fifo_stream_writer_if.slave   s_if,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  full,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy,
  output logic                  len_err
);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic                  len_err_q, len_err_d;

  logic                  out_valid;
  logic                  load_ok;
  logic                  ready;
  logic                  hs;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CNT_WIDTH-1:0]  word_inc;

  // The register can take a word if it is empty or is being written now.
  assign load_ok  = ~out_valid | ~full;
  assign word_inc = word_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    word_cnt_d  = word_cnt_q;
    len_err_d   = len_err_q;
    ready       = 1'b0;
    hs          = 1'b0;
    load        = 1'b0;
    load_data   = s_if.s_data;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
`ifdef FIFO_WR_HEADER_EN
          state_d = ST_HEADER;
`else
          state_d = ST_PAYLOAD;
`endif
        end
      end

`ifdef FIFO_WR_HEADER_EN
      ST_HEADER: begin
        if (load_ok) begin
          load      = 1'b1;
          load_data = DATA_WIDTH'(frame_cnt_q);
          state_d   = ST_PAYLOAD;
        end
      end
`endif

      ST_PAYLOAD: begin
        ready = load_ok;
        hs    = s_if.s_valid & ready;
        if (hs) begin
          load       = 1'b1;
          word_cnt_d = word_inc;
          // s_last wins over a coinciding max_len boundary.
          if (s_if.s_last) begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + 1'b1;
            word_cnt_d  = '0;
          end else if ((max_len != '0) && (word_inc == max_len)) begin
            state_d     = ST_DISCARD;
            frame_cnt_d = frame_cnt_q + 1'b1;
            len_err_d   = 1'b1;
          end
        end
      end

      ST_DISCARD: begin
        // Drain the rest of a truncated frame without writing it.
        ready = 1'b1;
        hs    = s_if.s_valid;
        if (hs && s_if.s_last) begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      word_cnt_q  <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_err_q   <= len_err_d;
    end
  end

  fifo_wr_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stage (
    .clk       (wr_clk),
    .rst_n     (wr_rst_n),
    .load      (load),
    .load_data (load_data),
    .full      (full),
    .out_valid (out_valid),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );

  assign s_if.s_ready = ready;
  assign frame_cnt    = frame_cnt_q;
  assign word_cnt     = word_cnt_q;
  assign len_err      = len_err_q;
  assign busy         = (state_q != ST_IDLE) | out_valid;

endmodule
